// File: rtl/inst_fetcher.sv
// rtl/inst_fetcher.sv - instruction fetch unit with single outstanding icache request and in-order issue queue
module inst_fetcher #(
    parameter int          QUEUE_DEPTH    = 16,
    parameter int          QUEUE_ID_WIDTH = 4,
    parameter logic [31:0] RESET_PC       = 32'h0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    output logic        req_valid_to_icache,
    output logic [31:0] addr_to_icache,
    input  logic        ready_from_icache,
    input  logic        valid_from_icache,
    input  logic [31:0] inst_from_icache,
    output logic [31:0] inst_to_br_predictor,
    output logic [31:0] pc_to_br_predictor,
    input  logic [31:0] next_pc_from_br_predictor,
    output logic        valid_to_issuer,
    output logic [31:0] inst_to_issuer,
    output logic [31:0] pc_to_issuer,
    output logic [31:0] predicted_pc_to_issuer,
    input  logic        ready_from_issuer,
    input  logic        reset_from_rob_bus,
    input  logic [31:0] pc_from_rob_bus
);

    typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

    localparam logic [QUEUE_ID_WIDTH:0]   CNT_ONE = 1;
    localparam logic [QUEUE_ID_WIDTH-1:0] PTR_ONE = 1;

    state_t                  state, state_next;
    logic [31:0]             pc;
    logic [QUEUE_ID_WIDTH-1:0] head, tail;
    logic [QUEUE_ID_WIDTH:0] count;
    logic [31:0]             inst_q [QUEUE_DEPTH];
    logic [31:0]             pc_q   [QUEUE_DEPTH];
    logic [31:0]             pred_q [QUEUE_DEPTH];
    logic                    flush, push, pop, queue_full;

    assign flush      = rdy && reset_from_rob_bus;
    // count tops out at exactly QUEUE_DEPTH, so its MSB alone marks full
    assign queue_full = count[QUEUE_ID_WIDTH];

    assign req_valid_to_icache  = !rst && rdy && (state == IDLE) && !queue_full && !reset_from_rob_bus;
    assign addr_to_icache       = pc;
    assign inst_to_br_predictor = inst_from_icache;
    assign pc_to_br_predictor   = pc;

    assign valid_to_issuer        = (count != '0);
    assign inst_to_issuer         = inst_q[head];
    assign pc_to_issuer           = pc_q[head];
    assign predicted_pc_to_issuer = pred_q[head];

    assign push = rdy && !reset_from_rob_bus && (state == WAIT) && valid_from_icache;
    assign pop  = rdy && !reset_from_rob_bus && valid_to_issuer && ready_from_issuer;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (req_valid_to_icache && ready_from_icache)
                    state_next = WAIT;
            end
            WAIT: begin
                if (valid_from_icache)
                    state_next = IDLE;
                else if (reset_from_rob_bus)
                    state_next = DISCARD;
            end
            DISCARD: begin
                if (valid_from_icache)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (!rdy)
            state_next = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pc    <= RESET_PC;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rdy) begin
            state <= state_next;
            if (flush) begin
                pc    <= pc_from_rob_bus;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    pc   <= next_pc_from_br_predictor;
                    tail <= tail + PTR_ONE;
                end
                if (pop)
                    head <= head + PTR_ONE;
                case ({push, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            inst_q[tail] <= inst_from_icache;
            pc_q[tail]   <= pc;
            pred_q[tail] <= next_pc_from_br_predictor;
        end
    end

endmodule

// File: tb/tb_inst_fetcher.sv
// tb/tb_inst_fetcher.sv - randomized bench for inst_fetcher against a queue-based reference model
module tb_inst_fetcher;

    localparam int          DEPTH = 16;
    localparam logic [31:0] RPC   = 32'h0;
    localparam logic [6:0]  JAL   = 7'b1101111;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic        req_valid_to_icache;
    logic [31:0] addr_to_icache;
    logic        ready_from_icache, valid_from_icache;
    logic [31:0] inst_from_icache;
    logic [31:0] inst_to_br_predictor, pc_to_br_predictor, next_pc_from_br_predictor;
    logic        valid_to_issuer;
    logic [31:0] inst_to_issuer, pc_to_issuer, predicted_pc_to_issuer;
    logic        ready_from_issuer, reset_from_rob_bus;
    logic [31:0] pc_from_rob_bus;

    inst_fetcher #(.QUEUE_DEPTH(DEPTH), .QUEUE_ID_WIDTH(4), .RESET_PC(RPC)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_valid_to_icache(req_valid_to_icache), .addr_to_icache(addr_to_icache),
        .ready_from_icache(ready_from_icache), .valid_from_icache(valid_from_icache),
        .inst_from_icache(inst_from_icache),
        .inst_to_br_predictor(inst_to_br_predictor), .pc_to_br_predictor(pc_to_br_predictor),
        .next_pc_from_br_predictor(next_pc_from_br_predictor),
        .valid_to_issuer(valid_to_issuer), .inst_to_issuer(inst_to_issuer),
        .pc_to_issuer(pc_to_issuer), .predicted_pc_to_issuer(predicted_pc_to_issuer),
        .ready_from_issuer(ready_from_issuer),
        .reset_from_rob_bus(reset_from_rob_bus), .pc_from_rob_bus(pc_from_rob_bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] predict(input logic [31:0] inst, input logic [31:0] pc);
        if (inst[6:0] == JAL)
            return pc + {{20{inst[31]}}, inst[31:20]};
        return pc + 32'd4;
    endfunction

    assign next_pc_from_br_predictor = predict(inst_to_br_predictor, pc_to_br_predictor);

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pred;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_pc;
    bit          m_out, m_squashed;
    int          delay;
    int          errors = 0;
    int          checks = 0;
    int          full_seen = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = RPC;
        m_out     = 0;
        m_squashed = 0;
        delay     = 0;
    endtask

    // mode 0: mixed, mode 1: issuer stalled and no flushes, mode 2: flush heavy
    task automatic step(input int mode);
        bit exp_req, accepted, do_pop;
        entry_t e;
        @(posedge clk);
        #1;
        rst                = (mode != 1) && ($urandom_range(0, 199) == 0);
        rdy                = ($urandom_range(0, 9) != 0);
        ready_from_icache  = ($urandom_range(0, 3) != 0);
        ready_from_issuer  = (mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        reset_from_rob_bus = (mode == 1) ? 1'b0 :
                             (mode == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 29) == 0);
        pc_from_rob_bus    = $urandom;
        inst_from_icache   = $urandom;
        if ($urandom_range(0, 3) == 0)
            inst_from_icache[6:0] = JAL;
        valid_from_icache  = m_out && (delay <= 1) && rdy && !rst;
        if (m_out && delay > 1)
            delay--;
        #4;
        exp_req = !rst && rdy && !m_out && (mq.size() < DEPTH) && !reset_from_rob_bus;
        check("req_valid", req_valid_to_icache, exp_req);
        if (exp_req)
            check("addr", addr_to_icache, m_pc);
        check("pc_to_bp", pc_to_br_predictor, m_pc);
        check("inst_to_bp", inst_to_br_predictor, inst_from_icache);
        check("valid_to_issuer", valid_to_issuer, mq.size() != 0);
        if (mq.size() != 0) begin
            check("head_inst", inst_to_issuer, mq[0].inst);
            check("head_pc", pc_to_issuer, mq[0].pc);
            check("head_pred", predicted_pc_to_issuer, mq[0].pred);
        end
        if (mq.size() == DEPTH)
            full_seen++;

        if (rst) begin
            model_reset();
        end else if (rdy) begin
            accepted = exp_req && ready_from_icache;
            if (reset_from_rob_bus) begin
                if (m_out) begin
                    if (valid_from_icache) begin
                        m_out      = 0;
                        m_squashed = 0;
                    end else begin
                        m_squashed = 1;
                    end
                end
                mq.delete();
                m_pc = pc_from_rob_bus;
            end else begin
                do_pop = (mq.size() != 0) && ready_from_issuer;
                if (m_out && valid_from_icache) begin
                    if (!m_squashed) begin
                        e.inst = inst_from_icache;
                        e.pc   = m_pc;
                        e.pred = predict(inst_from_icache, m_pc);
                        mq.push_back(e);
                        m_pc = e.pred;
                    end
                    m_out      = 0;
                    m_squashed = 0;
                end
                if (do_pop)
                    void'(mq.pop_front());
            end
            if (accepted) begin
                m_out = 1;
                delay = $urandom_range(1, 3);
            end
        end
    endtask

    initial begin
        rst = 1'b1; rdy = 1'b0; ready_from_icache = 1'b0; valid_from_icache = 1'b0;
        inst_from_icache = '0; ready_from_issuer = 1'b0; reset_from_rob_bus = 1'b0;
        pc_from_rob_bus = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #4;
        check("reset_valid_to_issuer", valid_to_issuer, 1'b0);
        check("reset_req_valid", req_valid_to_icache, 1'b0);
        check("reset_pc", addr_to_icache, RPC);
        for (int i = 0; i < 300; i++) step(0);
        for (int i = 0; i < 150; i++) step(1);
        for (int i = 0; i < 300; i++) step(0);
        for (int i = 0; i < 300; i++) step(2);
        for (int i = 0; i < 150; i++) step(1);
        for (int i = 0; i < 300; i++) step(0);
        checks++;
        if (full_seen == 0) begin
            errors++;
            $display("FAIL queue_full_reached: got %0d expected >0", full_seen);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
